// File: rtl/tail_light_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tail_light_sequencer                                       |
// | Description : Debounces stalk/hazard switches, arbitrates one command    |
// |               and drives the 6-lamp tail-light FSM with a step strobe.   |
// |               Optional turn auto-cancel: define TL_AUTOCANCEL_EN.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tail_light_sequencer #(
  parameter int unsigned DEB_CYCLES    = 4,
  parameter int unsigned STEP_DIV      = 8,
  parameter int unsigned SWEEP_STEPS   = 4,
  parameter int unsigned CANCEL_SWEEPS = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic stalk_left,
  input  logic stalk_right,
  input  logic haz_sw,
  output logic step_en,
  output logic left,
  output logic right,
  output logic haz,
  output logic active,
  output logic sweep_done
);

  localparam int unsigned c_DEB_W   = $clog2(DEB_CYCLES);
  localparam int unsigned c_DIV_W   = $clog2(STEP_DIV);
  localparam int unsigned c_SWEEP_W = $clog2(SWEEP_STEPS);
  localparam logic [c_DEB_W-1:0]   c_DEB_MAX   = c_DEB_W'(DEB_CYCLES - 1);
  localparam logic [c_DIV_W-1:0]   c_DIV_MAX   = c_DIV_W'(STEP_DIV - 1);
  localparam logic [c_SWEEP_W-1:0] c_SWEEP_MAX = c_SWEEP_W'(SWEEP_STEPS - 1);

  if (DEB_CYCLES < 2 || STEP_DIV < 2 || SWEEP_STEPS < 2 || CANCEL_SWEEPS < 1) begin : g_param_check
    $error("tail_light_sequencer: parameter out of range");
  end

`ifdef TL_AUTOCANCEL_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEFT    = 3'd1,
    ST_RIGHT   = 3'd2,
    ST_HAZ     = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEFT  = 3'd1,
    ST_RIGHT = 3'd2,
    ST_HAZ   = 3'd3
  } state_t;
`endif

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_LEFT  = 2'd1,
    REQ_RIGHT = 2'd2,
    REQ_HAZ   = 2'd3
  } req_t;

  function automatic state_t req_to_state(input req_t req);
    case (req)
      REQ_LEFT:  return ST_LEFT;
      REQ_RIGHT: return ST_RIGHT;
      REQ_HAZ:   return ST_HAZ;
      default:   return ST_IDLE;
    endcase
  endfunction

  // Bit order: [0] left stalk, [1] right stalk, [2] hazard switch
  logic [2:0] w_raw;
  logic [2:0] w_db;
  assign w_raw = {haz_sw, stalk_right, stalk_left};

  for (genvar gi = 0; gi < 3; gi++) begin : g_deb
    logic [c_DEB_W-1:0] r_cnt;
    logic               r_lvl;
    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else if (w_raw[gi] == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == c_DEB_MAX) begin
        r_cnt <= '0;
        r_lvl <= w_raw[gi];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
    assign w_db[gi] = r_lvl;
  end

  req_t w_req;
  always_comb begin
    w_req = REQ_NONE;
    if (w_db[2])                 w_req = REQ_HAZ;
    else if (w_db[0] && w_db[1]) w_req = REQ_NONE;
    else if (w_db[0])            w_req = REQ_LEFT;
    else if (w_db[1])            w_req = REQ_RIGHT;
  end

  logic [c_DIV_W-1:0] r_div;
  logic               r_step;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div  <= '0;
      r_step <= 1'b0;
    end else begin
      r_step <= (r_div == c_DIV_MAX);
      r_div  <= (r_div == c_DIV_MAX) ? '0 : r_div + 1'b1;
    end
  end

  state_t               r_state;
  state_t               w_next;
  logic [c_SWEEP_W-1:0] r_sweep;
  logic [c_SWEEP_W-1:0] w_sweep_nxt;
  logic [c_SWEEP_W-1:0] w_sweep_inc;
  logic                 w_sweep_done;

  assign w_sweep_inc  = (r_sweep == c_SWEEP_MAX) ? '0 : r_sweep + 1'b1;
  assign w_sweep_done = r_step && (r_sweep == c_SWEEP_MAX);

`ifdef TL_AUTOCANCEL_EN
  localparam int unsigned c_CANCEL_W = $clog2(CANCEL_SWEEPS + 1);
  localparam logic [c_CANCEL_W-1:0] c_CANCEL_MAX = c_CANCEL_W'(CANCEL_SWEEPS - 1);
  logic [c_CANCEL_W-1:0] r_cancel;

  always_ff @(posedge clk) begin
    if (reset || (w_next != r_state)) begin
      r_cancel <= '0;
    end else if (w_sweep_done && (r_state == ST_LEFT || r_state == ST_RIGHT)) begin
      r_cancel <= r_cancel + 1'b1;
    end
  end
`endif

  // Turns only change at a sweep boundary; hazard preempts at any strobe.
  always_comb begin
    w_next      = r_state;
    w_sweep_nxt = r_sweep;
    if (r_step) begin
      case (r_state)
        ST_IDLE: begin
          w_next      = req_to_state(w_req);
          w_sweep_nxt = '0;
        end
        ST_LEFT, ST_RIGHT: begin
          if (w_req == REQ_HAZ) begin
            w_next      = ST_HAZ;
            w_sweep_nxt = '0;
          end else begin
            w_sweep_nxt = w_sweep_inc;
            if (w_sweep_done) begin
              w_next = req_to_state(w_req);
`ifdef TL_AUTOCANCEL_EN
              if ((w_next == r_state) && (r_cancel == c_CANCEL_MAX)) w_next = ST_LOCKOUT;
`endif
            end
          end
        end
        ST_HAZ: begin
          w_sweep_nxt = w_sweep_inc;
          if (w_sweep_done && (w_req != REQ_HAZ)) w_next = req_to_state(w_req);
        end
`ifdef TL_AUTOCANCEL_EN
        ST_LOCKOUT: begin
          w_sweep_nxt = '0;
          if (w_req == REQ_HAZ)       w_next = ST_HAZ;
          else if (w_req == REQ_NONE) w_next = ST_IDLE;
        end
`endif
        default: begin
          w_next      = ST_IDLE;
          w_sweep_nxt = '0;
        end
      endcase
    end
  end

  logic r_left, r_right, r_haz, r_active;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_sweep  <= '0;
      r_left   <= 1'b0;
      r_right  <= 1'b0;
      r_haz    <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_sweep  <= w_sweep_nxt;
      r_left   <= (w_next == ST_LEFT)  || (w_next == ST_HAZ);
      r_right  <= (w_next == ST_RIGHT) || (w_next == ST_HAZ);
      r_haz    <= (w_next == ST_HAZ);
      r_active <= (w_next != ST_IDLE);
    end
  end

  assign step_en    = r_step;
  assign left       = r_left;
  assign right      = r_right;
  assign haz        = r_haz;
  assign active     = r_active;
  assign sweep_done = w_sweep_done;

endmodule
`default_nettype wire

// File: doc/tail_light_sequencer.md
# tail_light_sequencer

- Debounces the driver's raw stalk and hazard-switch inputs.
- Arbitrates them into a single command and emits the `left`/`right`/`haz` controls for the 6-lamp tail-light FSM.
- Generates that FSM's lamp-advance strobe.
- Sits between the switch inputs and the tail-light FSM; a command is only changed at a sweep boundary, so no sweep is cut short except by a hazard preempt.

## Interface
- `DEB_CYCLES`, 4: consecutive stable cycles required before a debounced level changes.
- `STEP_DIV`, 8: clock cycles per lamp-advance strobe.
- `SWEEP_STEPS`, 4: strobes per full lamp sweep (off plus 3 lamps).
- `CANCEL_SWEEPS`, 5: complete sweeps before a turn command auto-cancels (used only with `TL_AUTOCANCEL_EN`).
- `clk` in 1: the only clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `stalk_left` in 1: raw left-turn stalk.
- `stalk_right` in 1: raw right-turn stalk.
- `haz_sw` in 1: raw hazard switch.
- `step_en` out 1: one-cycle lamp-advance strobe to the tail-light FSM.
- `left` out 1: left command to the tail-light FSM.
- `right` out 1: right command to the tail-light FSM.
- `haz` out 1: hazard command to the tail-light FSM.
- `active` out 1: high in any state other than IDLE.
- `sweep_done` out 1: one-cycle pulse on the strobe that completes a sweep.

## Operation
- **Debounce**
  - Each raw input has its own counter and a debounced level register.
  - The counter counts while raw ≠ debounced level and clears when raw = level.
  - The level flips when the counter reaches `DEB_CYCLES`-1, and the counter clears.
- **Request resolution** (priority order):
  - `haz_db` → HAZ.
  - `left_db`&`right_db` → NONE (a conflicting stalk is ignored).
  - `left_db` only → LEFT.
  - `right_db` only → RIGHT.
  - Otherwise → NONE.
- **Prescaler**
  - Free-running counter from 0 to `STEP_DIV`-1, wrapping.
  - `step_en` is registered and is high in the cycle after the counter value `STEP_DIV`-1.
- **Sweep counter**
  - Advances on `step_en` in LEFT, RIGHT or HAZ; held at 0 in IDLE and LOCKOUT.
  - Wraps from `SWEEP_STEPS`-1 to 0.
  - `sweep_done` is high when `step_en` is high and the count is `SWEEP_STEPS`-1.
- **States:** IDLE, LEFT, RIGHT, HAZ, LOCKOUT. Transitions are evaluated only in cycles where `step_en`=1.
  - IDLE → requested state; the sweep counter stays 0. On NONE, stay in IDLE.
  - LEFT/RIGHT, any request = HAZ → HAZ immediately, sweep counter to 0 (preempt).
  - LEFT/RIGHT, other requests → acted on only at `sweep_done`:
    - same request → stay;
    - other turn → switch to it;
    - NONE → IDLE.
  - HAZ: leaves only at `sweep_done` when the request is not HAZ; goes to LEFT, RIGHT or IDLE per the request.
  - LOCKOUT: exists only with `TL_AUTOCANCEL_EN`. Exit is described under Configuration.
- **Output decode** (registered from the state):

| State | `left` | `right` | `haz` |
|---|---|---|---|
| IDLE, LOCKOUT | 0 | 0 | 0 |
| LEFT | 1 | 0 | 0 |
| RIGHT | 0 | 1 | 0 |
| HAZ | 1 | 1 | 1 |

## Timing
- **Reset values:**
  - all outputs 0;
  - state IDLE;
  - all counters 0;
  - debounced levels 0.
- **Reset mid-sweep:** returns to these values on the next edge; no sweep is completed.
- **Debounce latency:** a raw change held stable reaches the debounced level `DEB_CYCLES` edges after the first changed sample. A glitch shorter than that is fully rejected.
- **Command latency:**
  - Outputs change on the edge that samples `step_en`=1, so they are visible one cycle after the strobe cycle.
  - Worst-case latency from a debounced request to an output change from IDLE is `STEP_DIV` cycles.
- **Mid-sweep changes:** a stalk change during a turn sweep takes effect only at the end of that sweep (up to `SWEEP_STEPS`×`STEP_DIV` cycles). A hazard request preempts at the next strobe.
- **Simultaneous raw edges:** the debounced levels resolve independently; the priority rules apply to whatever levels exist at the strobe.

## Configuration
- Macro: `TL_AUTOCANCEL_EN`.
- **Defined:**
  - A sweep counter counts completed sweeps (`sweep_done`) in LEFT/RIGHT.
  - On reaching `CANCEL_SWEEPS`, the state goes to LOCKOUT instead of staying in the turn.
  - LOCKOUT exits on a strobe: to HAZ if requested; to IDLE once the request is NONE.
  - While LOCKOUT persists, the held stalk is ignored.
  - The sweep count clears on entering any state.
  - HAZ never auto-cancels.
- **Undefined:** no LOCKOUT state and no sweep count; a turn repeats for as long as it is requested.

## Test plan
Parameters for all scenarios: `DEB_CYCLES`=4, `STEP_DIV`=8, `SWEEP_STEPS`=4, `CANCEL_SWEEPS`=2.

1. **Reset:** hold `reset` for 3 cycles with all inputs at 1 → all outputs 0 throughout. After release, `step_en` first pulses 8 cycles later and then every 8 cycles.
2. **Glitch rejection:** a 3-cycle pulse on `stalk_left` → `left` stays 0 and `active` stays 0. A 4-cycle hold → `left`=1 after the next `step_en`.
3. **Sweep completion:** hold `stalk_left`, then release it after 1 strobe → `left` stays 1 through 4 strobes and drops at the `sweep_done` strobe. `sweep_done` pulses exactly once.
4. **Hazard preempt and conflict:**
   - `haz_sw` rises mid-LEFT → `haz`=`left`=`right`=1 at the very next strobe.
   - Both stalks held with no hazard → all outputs 0.
5. **Auto-cancel** (`TL_AUTOCANCEL_EN`): hold `stalk_right` → `right` drops after 2 `sweep_done` pulses and stays 0 while the stalk is held. After release and a fresh press, `right` returns to 1.
6. **No auto-cancel** (macro undefined): hold `stalk_right` for 20 strobes → `right` is 1 throughout, with 5 `sweep_done` pulses.
